regfile_cmd_unit: RTL and testbench
===================================

REGFILE_CMD_UNIT -- requirements
Module: regfile_cmd_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register width in bits; must be a multiple of 4 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of registers; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter ZERO_R0, default 0, meaning that when 1, r0 reads 0 and writes to it are discarded.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid, input, 1 bit: one-cycle strobe that starts a command.
REQ-007 SHALL have port cmd_op, input, 3 bits: opcode, sampled with cmd_valid.
REQ-008 SHALL have port nib_valid, input, 1 bit: one-cycle operand-nibble strobe.
REQ-009 SHALL have port nib, input, 4 bits: operand nibble, sampled with nib_valid.
REQ-010 SHALL have port abort, input, 1 bit: cancels the command in progress.
REQ-011 SHALL have port rsp_ready, input, 1 bit: consumer (LCD driver) accepts the response.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port rsp_valid, output, 1 bit: response is available.
REQ-014 SHALL have port rsp_addr, output, ADDR_W bits: address shown on display line 1.
REQ-015 SHALL have port rsp_a, output, DATA_W bits: first result word.
REQ-016 SHALL have port rsp_b, output, DATA_W bits: second result word.
REQ-017 SHALL have port cmd_err, output, 1 bit: one-cycle error pulse.

Function
REQ-018 Operand widths SHALL be: address field ADDR_NIB = ceil(ADDR_W/4) nibbles, taking the low ADDR_W bits; immediate DATA_W/4 nibbles; shift amount ceil(clog2(DATA_W)/4) nibbles, taking the low clog2(DATA_W) bits. Every field SHALL be entered MSB nibble first.
REQ-019 Operand order per op SHALL be:
- 0 WR: rd, imm; rsp = rd / imm / 0
- 1 RD: ra; rsp = ra / R[ra] / 0
- 2 RD2: ra, rb; rsp = ra / R[ra] / R[rb]
- 3 RDWR: ra, rd, imm; rsp = ra / R[ra] / imm
- 4 RD2WR: ra, rb, rd, imm; rsp = rd / R[ra] / R[rb]
- 5 SLT: ra, rb, rd; rsp = rd / result / 0
- 6 XOR: ra, rb, rd; rsp = rd / result / 0
- 7 SRA: ra, rd, sh; rsp = rd / result / 0
(each rsp triple is rsp_addr / rsp_a / rsp_b).
REQ-020 SLT SHALL write 1 when signed(R[ra]) < signed(R[rb]) and 0 otherwise, zero-extended to DATA_W; XOR SHALL write R[ra]^R[rb]; SRA SHALL write the arithmetic right shift R[ra]>>>sh.
REQ-021 The FSM SHALL have states IDLE, COLLECT, EXEC, RESP. IDLE goes to COLLECT on cmd_valid, latching op and clearing the nibble counter. COLLECT goes to EXEC on the edge that accepts the final nibble. EXEC lasts one cycle, then goes to RESP. RESP goes to IDLE on rsp_valid&&rsp_ready.
REQ-022 In EXEC, operands SHALL be read and the write SHALL be performed on the same edge; reads SHALL return pre-write contents, including when ra==rd.
REQ-023 Latency SHALL be: rsp_valid high in the cycle after EXEC, i.e. 2 edges after the final nibble; a write SHALL be visible to the next command.
REQ-024 rsp_addr, rsp_a and rsp_b SHALL be registered and SHALL remain stable while rsp_valid is high.
REQ-025 cmd_valid while not in IDLE SHALL be ignored and SHALL pulse cmd_err.
REQ-026 nib_valid outside COLLECT SHALL be ignored without error.
REQ-027 abort in COLLECT, EXEC or RESP SHALL return the FSM to IDLE on the next edge with no register write and rsp_valid low; abort SHALL win over a simultaneous nib_valid or rsp_ready.
REQ-028 An address >= DEPTH (non-power-of-two DEPTH) SHALL read as 0, SHALL drop the write, and SHALL pulse cmd_err in EXEC; the command otherwise completes.
REQ-029 With ZERO_R0=1, r0 SHALL read 0 and writes to r0 SHALL be dropped without error.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, clear all registers to 0, and force busy, rsp_valid, cmd_err, rsp_addr, rsp_a and rsp_b to 0; this holds mid-command as well.
REQ-031 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-032 Package regfile_cmd_pkg SHALL hold the opcode enum, the state enum, and the nibble-count functions.
REQ-033 Storage SHALL be the sub-module regfile_2r1w (2 asynchronous read ports, 1 synchronous write port, async-clear), parametrised by DATA_W and DEPTH.

Verification (DATA_W=16, DEPTH=32)
REQ-034 WR rd=0x05 imm=0xBEEF, then RD ra=0x05 -> second response rsp_addr=5, rsp_a=0xBEEF; rsp_valid rises 2 edges after the last nibble.
REQ-035 R1=0x8000, R2=0x0001; SLT ra=1 rb=2 rd=3 -> R3=0x0001. XOR ra=1 rb=2 rd=4 -> R4=0x8001. SRA ra=1 rd=6 sh=3 -> R6=0xF000.
REQ-036 RDWR ra=7 rd=7 imm=0x1234 with R7=0xAAAA -> rsp_a=0xAAAA, then a subsequent RD of 7 returns 0x1234.
REQ-037 Hold rsp_ready low for 10 cycles -> rsp fields stable; cmd_valid during that time -> cmd_err pulses once and the state is unchanged.
REQ-038 abort after 3 of 6 WR nibbles -> IDLE, target register unchanged; rst_n low mid-command -> all outputs 0 and R5 reads 0.
REQ-039 ZERO_R0=1: WR rd=0 imm=0xFFFF, then RD 0 -> rsp_a=0x0000; DEPTH=20: WR rd=25 -> cmd_err pulses and no write occurs.

Source files
------------

// File: rtl/regfile_cmd_pkg.sv
// rtl/regfile_cmd_pkg.sv - opcode/state enums and operand nibble-count helpers
package regfile_cmd_pkg;

    typedef enum logic [2:0] {
        OP_WR    = 3'd0,
        OP_RD    = 3'd1,
        OP_RD2   = 3'd2,
        OP_RDWR  = 3'd3,
        OP_RD2WR = 3'd4,
        OP_SLT   = 3'd5,
        OP_XOR   = 3'd6,
        OP_SRA   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EXEC    = 2'd2,
        RESP    = 2'd3
    } state_e;

    function automatic int addr_nibs(input int depth);
        return ($clog2(depth) + 3) / 4;
    endfunction

    function automatic int sh_nibs(input int data_w);
        return ($clog2(data_w) + 3) / 4;
    endfunction

    // an/dn/sn: nibbles per address, immediate and shift-amount field
    function automatic int op_nibs(input op_e op, input int an, input int dn, input int sn);
        case (op)
            OP_WR:          return an + dn;
            OP_RD:          return an;
            OP_RD2:         return 2 * an;
            OP_RDWR:        return 2 * an + dn;
            OP_RD2WR:       return 3 * an + dn;
            OP_SLT, OP_XOR: return 3 * an;
            default:        return 2 * an + sn;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - register array, two async read ports, one sync write port
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/regfile_cmd_unit.sv
// rtl/regfile_cmd_unit.sv - nibble-serial command front end for a 2R1W register file
module regfile_cmd_unit
    import regfile_cmd_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 32,
    parameter int ZERO_R0 = 0,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic              nib_valid,
    input  logic [3:0]        nib,
    input  logic              abort,
    input  logic              rsp_ready,
    output logic              busy,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              cmd_err
);
    localparam int AN    = addr_nibs(DEPTH);
    localparam int DN    = DATA_W / 4;
    localparam int SH_W  = $clog2(DATA_W);
    localparam int SN    = sh_nibs(DATA_W);
    localparam int LA    = 4 * AN;
    localparam int LS    = 4 * SN;
    localparam int MAX_N = 3 * AN + DN;
    localparam int SR_W  = 4 * MAX_N;
    localparam int CNT_W = $clog2(MAX_N + 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;
    logic              cmd_err_q, cmd_err_d;

    logic [ADDR_W-1:0] ra, rb, rd;
    logic [DATA_W-1:0] imm;
    logic [SH_W-1:0]   sh;
    logic              ra_oob, rb_oob, rd_oob;
    logic [DATA_W-1:0] rdata_a, rdata_b, a_val, b_val, result;
    logic              we, last_nib;

    // Fields are shifted in MSB first, so the last operand sits at the bottom.
    always_comb begin
        ra  = '0;
        rb  = '0;
        rd  = '0;
        imm = sr_q[0 +: DATA_W];
        sh  = sr_q[0 +: SH_W];
        case (op_q)
            OP_WR:    rd = sr_q[DATA_W +: ADDR_W];
            OP_RD:    ra = sr_q[0 +: ADDR_W];
            OP_RD2: begin
                rb = sr_q[0 +: ADDR_W];
                ra = sr_q[LA +: ADDR_W];
            end
            OP_RDWR: begin
                rd = sr_q[DATA_W +: ADDR_W];
                ra = sr_q[DATA_W + LA +: ADDR_W];
            end
            OP_RD2WR: begin
                rd = sr_q[DATA_W +: ADDR_W];
                rb = sr_q[DATA_W + LA +: ADDR_W];
                ra = sr_q[DATA_W + 2 * LA +: ADDR_W];
            end
            OP_SLT, OP_XOR: begin
                rd = sr_q[0 +: ADDR_W];
                rb = sr_q[LA +: ADDR_W];
                ra = sr_q[2 * LA +: ADDR_W];
            end
            default: begin
                rd = sr_q[LS +: ADDR_W];
                ra = sr_q[LS + LA +: ADDR_W];
            end
        endcase
    end

    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign ra_oob = 1'b0;
        assign rb_oob = 1'b0;
        assign rd_oob = 1'b0;
    end else begin : g_npow2
        assign ra_oob = ra > ADDR_W'(DEPTH - 1);
        assign rb_oob = rb > ADDR_W'(DEPTH - 1);
        assign rd_oob = rd > ADDR_W'(DEPTH - 1);
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (ra),
        .raddr_b (rb),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .we      (we),
        .waddr   (rd),
        .wdata   (result)
    );

    assign a_val = (ra_oob || (ZERO_R0 != 0 && ra == '0)) ? '0 : rdata_a;
    assign b_val = (rb_oob || (ZERO_R0 != 0 && rb == '0)) ? '0 : rdata_b;

    always_comb begin
        result = imm;
        case (op_q)
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, $signed(a_val) < $signed(b_val)};
            OP_XOR:  result = a_val ^ b_val;
            OP_SRA:  result = $signed(a_val) >>> sh;
            default: result = imm;
        endcase
    end

    assign we = (state_q == EXEC) && !abort && (op_q != OP_RD) && (op_q != OP_RD2)
                && !rd_oob && !(ZERO_R0 != 0 && rd == '0);

    assign last_nib = (int'(cnt_q) == op_nibs(op_q, AN, DN, SN) - 1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        rsp_addr_d = rsp_addr_q;
        rsp_a_d    = rsp_a_q;
        rsp_b_d    = rsp_b_q;
        cmd_err_d  = cmd_valid && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = COLLECT;
                    op_d    = op_e'(cmd_op);
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (nib_valid) begin
                    sr_d  = {sr_q[SR_W-5:0], nib};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_nib) begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d    = RESP;
                    cmd_err_d  = cmd_err_d || ra_oob || rb_oob || rd_oob;
                    rsp_addr_d = rd;
                    rsp_a_d    = result;
                    rsp_b_d    = '0;
                    case (op_q)
                        OP_RD: begin
                            rsp_addr_d = ra;
                            rsp_a_d    = a_val;
                        end
                        OP_RD2: begin
                            rsp_addr_d = ra;
                            rsp_a_d    = a_val;
                            rsp_b_d    = b_val;
                        end
                        OP_RDWR: begin
                            rsp_addr_d = ra;
                            rsp_a_d    = a_val;
                            rsp_b_d    = imm;
                        end
                        OP_RD2WR: begin
                            rsp_a_d = a_val;
                            rsp_b_d = b_val;
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (abort || rsp_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= OP_WR;
            cnt_q      <= '0;
            sr_q       <= '0;
            rsp_addr_q <= '0;
            rsp_a_q    <= '0;
            rsp_b_q    <= '0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_a_q    <= rsp_a_d;
            rsp_b_q    <= rsp_b_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_addr  = rsp_addr_q;
    assign rsp_a     = rsp_a_q;
    assign rsp_b     = rsp_b_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_regfile_cmd_unit.sv
// tb/tb_regfile_cmd_unit.sv - directed bench for regfile_cmd_unit (default, ZERO_R0=1, DEPTH=20)
module tb_regfile_cmd_unit;

    localparam logic [2:0] WR = 3'd0, RD = 3'd1, RD2 = 3'd2, RDWR = 3'd3;
    localparam logic [2:0] RD2WR = 3'd4, SLT = 3'd5, XOR = 3'd6, SRA = 3'd7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       nib_valid = 1'b0;
    logic [3:0] nib = 4'd0;
    logic       abort = 1'b0;
    logic       rsp_ready = 1'b0;

    logic        m_busy, m_rsp_valid, m_cmd_err;
    logic [4:0]  m_rsp_addr;
    logic [15:0] m_rsp_a, m_rsp_b;
    logic        z_busy, z_rsp_valid, z_cmd_err;
    logic [4:0]  z_rsp_addr;
    logic [15:0] z_rsp_a, z_rsp_b;
    logic        d_busy, d_rsp_valid, d_cmd_err;
    logic [4:0]  d_rsp_addr;
    logic [15:0] d_rsp_a, d_rsp_b;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    int errs;

    always #5 clk = ~clk;

    regfile_cmd_unit #(.DATA_W(16), .DEPTH(32), .ZERO_R0(0)) u_main (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .nib_valid(nib_valid), .nib(nib), .abort(abort), .rsp_ready(rsp_ready),
        .busy(m_busy), .rsp_valid(m_rsp_valid), .rsp_addr(m_rsp_addr),
        .rsp_a(m_rsp_a), .rsp_b(m_rsp_b), .cmd_err(m_cmd_err)
    );

    regfile_cmd_unit #(.DATA_W(16), .DEPTH(32), .ZERO_R0(1)) u_z (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .nib_valid(nib_valid), .nib(nib), .abort(abort), .rsp_ready(rsp_ready),
        .busy(z_busy), .rsp_valid(z_rsp_valid), .rsp_addr(z_rsp_addr),
        .rsp_a(z_rsp_a), .rsp_b(z_rsp_b), .cmd_err(z_cmd_err)
    );

    regfile_cmd_unit #(.DATA_W(16), .DEPTH(20), .ZERO_R0(0)) u_d20 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .nib_valid(nib_valid), .nib(nib), .abort(abort), .rsp_ready(rsp_ready),
        .busy(d_busy), .rsp_valid(d_rsp_valid), .rsp_addr(d_rsp_addr),
        .rsp_a(d_rsp_a), .rsp_b(d_rsp_b), .cmd_err(d_cmd_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic nibs(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            nib_valid = 1'b1;
            nib       = v[4*i +: 4];
            tick();
        end
        nib_valid = 1'b0;
    endtask

    // Leaves the unit in RESP with the response on the outputs.
    task automatic run(input logic [2:0] op, input logic [63:0] v, input int n);
        start(op);
        nibs(v, n);
        tick();
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy", m_busy, 0);
        check("rst_rsp_valid", m_rsp_valid, 0);
        check("rst_cmd_err", m_cmd_err, 0);
        check("rst_rsp_addr", m_rsp_addr, 0);
        check("rst_rsp_a", m_rsp_a, 0);
        check("rst_rsp_b", m_rsp_b, 0);

        // first edge after deassertion accepts a command
        rst_n     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = WR;
        tick();
        cmd_valid = 1'b0;
        check("first_accept_busy", m_busy, 1);
        nibs({8'h05, 16'hBEEF}, 6);
        check("lat_exec_valid", m_rsp_valid, 0);
        check("lat_exec_busy", m_busy, 1);
        tick();
        check("lat_resp_valid", m_rsp_valid, 1);
        check("wr_rsp_addr", m_rsp_addr, 5);
        check("wr_rsp_a", m_rsp_a, 16'hBEEF);
        check("wr_rsp_b", m_rsp_b, 0);
        ack();
        check("idle_after_ack", m_busy, 0);
        run(RD, {8'h05}, 2);
        check("rd5_addr", m_rsp_addr, 5);
        check("rd5_a", m_rsp_a, 16'hBEEF);
        check("rd5_b", m_rsp_b, 0);
        ack();

        run(WR, {8'h01, 16'h8000}, 6); ack();
        run(WR, {8'h02, 16'h0001}, 6); ack();
        run(SLT, {8'h01, 8'h02, 8'h03}, 6);
        check("slt_addr", m_rsp_addr, 3);
        check("slt_a", m_rsp_a, 16'h0001);
        check("slt_b", m_rsp_b, 0);
        ack();
        run(SLT, {8'h02, 8'h01, 8'h0C}, 6);
        check("slt_rev_a", m_rsp_a, 16'h0000);
        ack();
        run(XOR, {8'h01, 8'h02, 8'h04}, 6);
        check("xor_addr", m_rsp_addr, 4);
        check("xor_a", m_rsp_a, 16'h8001);
        ack();
        run(SRA, {8'h01, 8'h06, 4'h3}, 5);
        check("sra_addr", m_rsp_addr, 6);
        check("sra_a", m_rsp_a, 16'hF000);
        ack();
        run(RD2, {8'h03, 8'h04}, 4);
        check("rd2_addr", m_rsp_addr, 3);
        check("rd2_a", m_rsp_a, 16'h0001);
        check("rd2_b", m_rsp_b, 16'h8001);
        ack();
        run(RD, {8'h06}, 2);
        check("rd6_a", m_rsp_a, 16'hF000);
        ack();

        run(WR, {8'h07, 16'hAAAA}, 6); ack();
        run(RDWR, {8'h07, 8'h07, 16'h1234}, 8);
        check("rdwr_addr", m_rsp_addr, 7);
        check("rdwr_a_prewrite", m_rsp_a, 16'hAAAA);
        check("rdwr_b", m_rsp_b, 16'h1234);
        ack();
        run(RD, {8'h07}, 2);
        check("rd7_after_rdwr", m_rsp_a, 16'h1234);
        ack();
        run(RD2WR, {8'h01, 8'h02, 8'h08, 16'h5A5A}, 10);
        check("rd2wr_addr", m_rsp_addr, 8);
        check("rd2wr_a", m_rsp_a, 16'h8000);
        check("rd2wr_b", m_rsp_b, 16'h0001);
        ack();
        run(RD, {8'h08}, 2);
        check("rd8_after_rd2wr", m_rsp_a, 16'h5A5A);
        ack();

        // back-pressure with a stray command
        run(RD, {8'h05}, 2);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i == 3);
            cmd_op    = WR;
            tick();
            cmd_valid = 1'b0;
            if (m_cmd_err) errs++;
            check("stall_rsp_a", m_rsp_a, 16'hBEEF);
        end
        check("stall_err_once", errs, 1);
        check("stall_valid", m_rsp_valid, 1);
        check("stall_addr", m_rsp_addr, 5);
        ack();

        // abort in COLLECT beats nib_valid
        start(WR);
        nibs(12'h09C, 3);
        abort     = 1'b1;
        nib_valid = 1'b1;
        nib       = 4'hA;
        tick();
        abort     = 1'b0;
        nib_valid = 1'b0;
        check("abort_collect_busy", m_busy, 0);
        nibs(12'hAFE, 3);
        check("stray_nib_busy", m_busy, 0);
        check("stray_nib_err", m_cmd_err, 0);
        run(RD, {8'h09}, 2);
        check("abort_collect_nowrite", m_rsp_a, 0);
        ack();

        start(WR);
        nibs({8'h0B, 16'h2222}, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_exec_valid", m_rsp_valid, 0);
        check("abort_exec_busy", m_busy, 0);
        run(RD, {8'h0B}, 2);
        check("abort_exec_nowrite", m_rsp_a, 0);
        ack();

        run(WR, {8'h0A, 16'h1111}, 6);
        abort     = 1'b1;
        rsp_ready = 1'b1;
        tick();
        abort     = 1'b0;
        rsp_ready = 1'b0;
        check("abort_resp_valid", m_rsp_valid, 0);
        check("abort_resp_busy", m_busy, 0);
        run(RD, {8'h0A}, 2);
        check("abort_resp_written", m_rsp_a, 16'h1111);
        ack();

        // reset while a response is pending
        run(RD, {8'h05}, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", m_busy, 0);
        check("midrst_valid", m_rsp_valid, 0);
        check("midrst_addr", m_rsp_addr, 0);
        check("midrst_a", m_rsp_a, 0);
        check("midrst_b", m_rsp_b, 0);
        check("midrst_err", m_cmd_err, 0);
        tick();
        rst_n = 1'b1;
        run(RD, {8'h05}, 2);
        check("midrst_r5_cleared", m_rsp_a, 0);
        ack();

        run(WR, {8'h00, 16'hFFFF}, 6);
        check("zr0_wr_noerr", z_cmd_err, 0);
        ack();
        run(RD, {8'h00}, 2);
        check("zr0_rd_zero", z_rsp_a, 16'h0000);
        check("r0_normal_rd", m_rsp_a, 16'hFFFF);
        ack();

        run(WR, {8'd25, 16'h7777}, 6);
        check("d20_oob_err", d_cmd_err, 1);
        check("d20_oob_addr", d_rsp_addr, 25);
        check("main_inrange_noerr", m_cmd_err, 0);
        ack();
        check("d20_err_pulse_end", d_cmd_err, 0);
        run(RD, {8'd25}, 2);
        check("d20_oob_read_zero", d_rsp_a, 0);
        check("d20_oob_read_err", d_cmd_err, 1);
        check("main_r25", m_rsp_a, 16'h7777);
        ack();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
